fetch_byte_sequencer: RTL and testbench
=======================================

# fetch_byte_sequencer

Instruction-fetch front end of the MIPS core. It accepts a word-aligned fetch request from the core's fetch stage, drives four consecutive byte addresses onto the 8-bit external address pins, samples the 8-bit external data pins for each byte, and assembles a big-endian 32-bit instruction. It presents that instruction to the core with a valid/ack handshake, and a flush aborts the fetch.

## Interface

Parameters:
- `WAIT_CYCLES`, default 1: extra cycles each byte address is held before `data_in` is sampled. Legal range is 0..15.
- `ADDR_W`, default 8: byte-address width. This is the external address-pin width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `fetch_req`  in  1: core requests an instruction word.
- `fetch_addr`  in  ADDR_W: byte address of the word. Bits [1:0] are ignored and treated as 00.
- `fetch_ready`  out  1: sequencer can accept a request. Combinational decode of state == IDLE.
- `flush`  in  1: abort the fetch in progress or discard the held instruction.
- `instr`  out  32: assembled instruction word.
- `instr_valid`  out  1: `instr` is complete and stable.
- `instr_ack`  in  1: core consumes `instr`.
- `data_in`  in  8: byte returned by external memory (from the chip's dedicated inputs).
- `address_out`  out  ADDR_W: byte address driven to external memory (to the chip's IO outputs).
- `busy`  out  1: high in FETCH state.

## Operation

Reset values:
- State is IDLE.
- `instr`, `address_out`, the byte index and the wait counter are 0.
- `instr_valid` and `busy` are 0.
- `fetch_ready` is 1. Any `fetch_req` while `rst` is high is ignored.

State IDLE:
- A request is accepted on a rising edge where `fetch_req` is 1 and `flush` is 0.
- On acceptance: latch base = {`fetch_addr`[ADDR_W-1:2], 2'b00}, set byte index to 0, clear the wait counter, go to FETCH.
- `address_out` holds its last value while idle.

State FETCH:
- `address_out` = {base[ADDR_W-1:2], byte_idx}. The address therefore never carries out of the aligned word; no wrap-around into the next word.
- Each edge: if the wait counter equals `WAIT_CYCLES`, capture `data_in` into the byte slot and clear the counter. Otherwise increment the counter.
- Byte slot mapping (big-endian): byte 0 goes to `instr`[31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
- After the byte 0..2 captures: byte_idx increments and `address_out` advances.
- After the byte 3 capture: go to VALID. byte_idx wraps to 0 but `address_out` keeps showing base|3.
- `instr` updates byte-by-byte during FETCH; the core must only use it while `instr_valid` is 1.

State VALID:
- `instr_valid` = 1 and `instr` is held constant.
- On `instr_ack` = 1, go to IDLE.
- `fetch_req` is not accepted in VALID; `fetch_ready` is 0.

Flush:
- `flush` = 1 in FETCH or VALID: go to IDLE on the next edge.
- A flush aborts the fetch or discards the word. `instr` keeps its partial or old contents; no byte is captured on the flush edge.
- Flush takes priority over `instr_ack` and over byte capture.
- Flush in IDLE blocks acceptance of a simultaneous `fetch_req`.

Reset mid-operation: returns everything immediately (asynchronously) to the reset values above. An outstanding fetch is lost.

## Timing

- Let edge E0 be the acceptance edge.
- Byte k (k = 0..3) is sampled at edge E0 + (k+1)·(WAIT_CYCLES+1).
- `address_out` for byte k is valid from E0 + k·(WAIT_CYCLES+1) until the sample edge of byte k. The external memory sees each address for WAIT_CYCLES+1 full cycles before sampling.
- `instr_valid` rises after edge E0 + 4·(WAIT_CYCLES+1). With the default WAIT_CYCLES = 1 this is 8 cycles; with WAIT_CYCLES = 0 it is 4 cycles.
- `instr_ack` seen on edge Ea: `instr_valid` falls after Ea and `fetch_ready` rises after Ea.
- The earliest next acceptance is edge Ea+1. Back-to-back throughput is one word per 4·(WAIT_CYCLES+1)+2 cycles with immediate acks.
- `busy` is high from after E0 through the final sample edge.

## Test plan

- **Reset/idle.** Assert `rst` mid-cycle -> outputs go to reset values without a clock edge. Release, then hold `fetch_req` = 0 for 10 cycles -> `fetch_ready` = 1, `instr_valid` = 0, `address_out` = 0.
- **Basic fetch, WAIT_CYCLES = 1.** Request `fetch_addr` = 0x13 (aligned to 0x10). Memory model returns 0x3C, 0x08, 0x00, 0x2A for addresses 0x10..0x13 -> `address_out` steps 0x10, 0x11, 0x12, 0x13, each for 2 cycles. `instr_valid` rises 8 cycles after acceptance with `instr` = 0x3C08002A.
- **WAIT_CYCLES = 0, back-to-back.** Fetch 0xFC then 0x00 with ack in the first VALID cycle -> addresses 0xFC..0xFF then 0x00..0x03, no wrap within a word. Valid after 4 cycles each; the second acceptance comes 1 cycle after the ack.
- **Flush during FETCH.** Assert `flush` on the edge after byte 1 is sampled -> IDLE next cycle, `instr_valid` never asserts. A new fetch of 0x20 then completes correctly with all 4 bytes.
- **Simultaneous events.** In VALID, assert `flush` and `instr_ack` together -> IDLE with no extra valid. In IDLE, assert `flush` and `fetch_req` together -> request not accepted, `busy` stays 0.
- **Hold in VALID.** Withhold `instr_ack` for 20 cycles while toggling `data_in` and `fetch_req` -> `instr` unchanged, `instr_valid` held at 1, `fetch_ready` held at 0.

Source files
------------

// File: rtl/fetch_byte_sequencer.sv
// Instruction-fetch byte sequencer: turns one word-aligned fetch request into four
// byte reads on the external 8-bit bus and assembles a big-endian 32-bit instruction.
// Latency: instr_valid rises 4*(WAIT_CYCLES+1) cycles after the acceptance edge.
// Backpressure: the word is held in VALID until instr_ack; no new request is taken until then.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   fetch_req, fetch_addr     request from fetch stage (addr[1:0] ignored)
//   fetch_ready               high in IDLE
//   flush                     abort fetch / drop held word
//   instr, instr_valid        assembled word and its valid flag
//   instr_ack                 core consumes instr
//   data_in, address_out      external memory byte bus
//   busy                      high while bytes are being fetched
module fetch_byte_sequencer #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              flush,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic [7:0]        data_in,
  output logic [ADDR_W-1:0] address_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        byte_idx_q;
  logic [3:0]        wait_q;
  logic [31:0]       instr_q;

  logic accept;
  logic capture;

  // Flush wins over everything: it blocks acceptance and suppresses capture.
  assign accept  = (state_q == IDLE) && fetch_req && !flush;
  assign capture = (state_q == FETCH) && !flush && (wait_q == WAIT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = FETCH;
      end
      FETCH: begin
        if (flush) begin
          state_d = IDLE;
        end else if (capture && (byte_idx_q == 2'd3)) begin
          state_d = VALID;
        end
      end
      VALID: begin
        if (flush || instr_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    fetch_ready = (state_q == IDLE);
    busy        = (state_q == FETCH);
    instr_valid = (state_q == VALID);
  end

  // Datapath. addr_q holds the aligned base in its upper bits and the current byte
  // index in [1:0]; after the last byte it is left at base|3 rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      byte_idx_q <= 2'd0;
      wait_q     <= 4'd0;
      instr_q    <= 32'd0;
    end else if (accept) begin
      addr_q     <= {fetch_addr[ADDR_W-1:2], 2'b00};
      byte_idx_q <= 2'd0;
      wait_q     <= 4'd0;
    end else if ((state_q == FETCH) && !flush) begin
      if (capture) begin
        wait_q     <= 4'd0;
        byte_idx_q <= byte_idx_q + 2'd1;
        case (byte_idx_q)
          2'd0:    instr_q[31:24] <= data_in;
          2'd1:    instr_q[23:16] <= data_in;
          2'd2:    instr_q[15:8]  <= data_in;
          default: instr_q[7:0]   <= data_in;
        endcase
        if (byte_idx_q != 2'd3) begin
          addr_q[1:0] <= byte_idx_q + 2'd1;
        end
      end else begin
        wait_q <= wait_q + 4'd1;
      end
    end
  end

  assign instr       = instr_q;
  assign address_out = addr_q;

endmodule

// File: tb/tb_fetch_byte_sequencer.sv
module tb_fetch_byte_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] noise;

  // Index 0: WAIT_CYCLES=1 instance, index 1: WAIT_CYCLES=0 instance.
  logic        req_s   [2];
  logic [7:0]  faddr_s [2];
  logic        flush_s [2];
  logic        ack_s   [2];
  logic [7:0]  data_s  [2];
  logic [7:0]  aout_s  [2];
  logic [31:0] instr_s [2];
  logic        valid_s [2];
  logic        ready_s [2];
  logic        busy_s  [2];

  int checks;
  int failures;

  fetch_byte_sequencer #(.WAIT_CYCLES(1), .ADDR_W(8)) dut_w1 (
    .clk(clk), .rst(rst),
    .fetch_req(req_s[0]), .fetch_addr(faddr_s[0]), .fetch_ready(ready_s[0]),
    .flush(flush_s[0]), .instr(instr_s[0]), .instr_valid(valid_s[0]),
    .instr_ack(ack_s[0]), .data_in(data_s[0]), .address_out(aout_s[0]),
    .busy(busy_s[0])
  );

  fetch_byte_sequencer #(.WAIT_CYCLES(0), .ADDR_W(8)) dut_w0 (
    .clk(clk), .rst(rst),
    .fetch_req(req_s[1]), .fetch_addr(faddr_s[1]), .fetch_ready(ready_s[1]),
    .flush(flush_s[1]), .instr(instr_s[1]), .instr_valid(valid_s[1]),
    .instr_ack(ack_s[1]), .data_in(data_s[1]), .address_out(aout_s[1]),
    .busy(busy_s[1])
  );

  // External memory: a few fixed bytes, everything else addr ^ 0x5A.
  function automatic logic [7:0] mem(input logic [7:0] a);
    case (a)
      8'h10:   mem = 8'h3C;
      8'h11:   mem = 8'h08;
      8'h12:   mem = 8'h00;
      8'h13:   mem = 8'h2A;
      default: mem = a ^ 8'h5A;
    endcase
  endfunction

  assign data_s[0] = mem(aout_s[0]) ^ noise;
  assign data_s[1] = mem(aout_s[1]) ^ noise;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one fetch, check the address walk cycle by cycle, the latency and the word.
  task automatic do_fetch(input int sel, input logic [7:0] addr, input logic [31:0] exp,
                          input bit do_ack);
    int per;
    logic [7:0] base;
    per  = (sel == 0) ? 2 : 1;
    base = {addr[7:2], 2'b00};
    faddr_s[sel] = addr;
    req_s[sel]   = 1'b1;
    step();                                   // acceptance edge E0
    req_s[sel]   = 1'b0;
    for (int c = 0; c < 4 * per; c++) begin
      chk("fetch_busy",  32'(busy_s[sel]),  32'd1);
      chk("fetch_valid", 32'(valid_s[sel]), 32'd0);
      chk("fetch_addr",  32'(aout_s[sel]),  32'(base | 8'(c / per)));
      step();
    end
    chk("valid_rise",  32'(valid_s[sel]), 32'd1);
    chk("valid_busy",  32'(busy_s[sel]),  32'd0);
    chk("valid_ready", 32'(ready_s[sel]), 32'd0);
    chk("valid_instr", instr_s[sel],      exp);
    chk("valid_addr",  32'(aout_s[sel]),  32'(base | 8'd3));
    if (do_ack) begin
      ack_s[sel] = 1'b1;
      step();
      ack_s[sel] = 1'b0;
      chk("ack_valid", 32'(valid_s[sel]), 32'd0);
      chk("ack_ready", 32'(ready_s[sel]), 32'd1);
    end
  endtask

  typedef struct {
    int          sel;
    logic [7:0]  addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    checks   = 0;
    failures = 0;
    noise    = 8'h00;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b1; faddr_s[i] = 8'h44; flush_s[i] = 1'b0; ack_s[i] = 1'b0;
    end

    vecs[0] = '{0, 8'h13, 32'h3C08002A};
    vecs[1] = '{1, 8'hFC, 32'hA6A7A4A5};
    vecs[2] = '{1, 8'h00, 32'h5A5B5859};   // back-to-back after vecs[1]
    vecs[3] = '{0, 8'h20, 32'h7A7B7879};

    // Reset with fetch_req held high: must be ignored.
    rst = 1'b1;
    step();
    step();
    req_s[0] = 1'b0;
    req_s[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(ready_s[i]), 32'd1);
      chk("rst_busy",  32'(busy_s[i]),  32'd0);
      chk("rst_valid", 32'(valid_s[i]), 32'd0);
      chk("rst_addr",  32'(aout_s[i]),  32'd0);
      chk("rst_instr", instr_s[i],      32'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_ready", 32'(ready_s[0]), 32'd1);
      chk("idle_valid", 32'(valid_s[0]), 32'd0);
      chk("idle_addr",  32'(aout_s[0]),  32'd0);
    end

    // Asynchronous reset mid-fetch, between clock edges.
    faddr_s[0] = 8'h10;
    req_s[0]   = 1'b1;
    step();
    req_s[0]   = 1'b0;
    step();
    step();
    step();
    chk("pre_arst_instr", 32'(instr_s[0][31:24]), 32'h3C);
    chk("pre_arst_addr",  32'(aout_s[0]),         32'h11);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy",  32'(busy_s[0]),  32'd0);
    chk("arst_ready", 32'(ready_s[0]), 32'd1);
    chk("arst_addr",  32'(aout_s[0]),  32'd0);
    chk("arst_instr", instr_s[0],      32'd0);
    step();
    rst = 1'b0;
    step();

    // Directed fetch table.
    for (int i = 0; i < 4; i++) begin
      do_fetch(vecs[i].sel, vecs[i].addr, vecs[i].exp, 1'b1);
    end

    // Hold in VALID without ack while inputs churn.
    do_fetch(0, 8'h13, 32'h3C08002A, 1'b0);
    for (int c = 0; c < 20; c++) begin
      noise    = 8'($urandom);
      req_s[0] = c[0];
      step();
      chk("hold_instr", instr_s[0],          32'h3C08002A);
      chk("hold_valid", 32'(valid_s[0]),     32'd1);
      chk("hold_ready", 32'(ready_s[0]),     32'd0);
    end
    noise    = 8'h00;
    req_s[0] = 1'b0;
    ack_s[0] = 1'b1;
    step();
    ack_s[0] = 1'b0;
    chk("hold_ack_ready", 32'(ready_s[0]), 32'd1);

    // Flush on the edge after byte 1 is sampled (WAIT_CYCLES=1).
    faddr_s[0] = 8'h40;
    req_s[0]   = 1'b1;
    step();                                   // E0
    req_s[0]   = 1'b0;
    for (int c = 0; c < 4; c++) step();       // now after E0+4 (byte 1 sampled)
    flush_s[0] = 1'b1;
    step();                                   // E0+5
    flush_s[0] = 1'b0;
    chk("flush_busy",  32'(busy_s[0]),  32'd0);
    chk("flush_ready", 32'(ready_s[0]), 32'd1);
    chk("flush_instr", instr_s[0],      32'h1A1B002A);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("flush_novalid", 32'(valid_s[0]), 32'd0);
    end
    do_fetch(0, 8'h20, 32'h7A7B7879, 1'b1);

    // Flush and ack together in VALID.
    do_fetch(1, 8'h00, 32'h5A5B5859, 1'b0);
    flush_s[1] = 1'b1;
    ack_s[1]   = 1'b1;
    step();
    flush_s[1] = 1'b0;
    ack_s[1]   = 1'b0;
    chk("fa_valid", 32'(valid_s[1]), 32'd0);
    chk("fa_ready", 32'(ready_s[1]), 32'd1);
    step();
    chk("fa_valid2", 32'(valid_s[1]), 32'd0);

    // Flush and request together in IDLE: request dropped.
    faddr_s[1] = 8'h08;
    flush_s[1] = 1'b1;
    req_s[1]   = 1'b1;
    step();
    flush_s[1] = 1'b0;
    req_s[1]   = 1'b0;
    chk("fr_busy",  32'(busy_s[1]),  32'd0);
    chk("fr_ready", 32'(ready_s[1]), 32'd1);
    step();
    chk("fr_busy2", 32'(busy_s[1]),  32'd0);

    // Flush landing on a capture edge (WAIT_CYCLES=0): byte 1 must not be written.
    faddr_s[1] = 8'h40;
    req_s[1]   = 1'b1;
    step();                                   // E0
    req_s[1]   = 1'b0;
    step();                                   // E1: byte 0 captured
    flush_s[1] = 1'b1;
    step();                                   // E2: would capture byte 1
    flush_s[1] = 1'b0;
    chk("flush_cap_instr", instr_s[1],      32'h1A5B5859);
    chk("flush_cap_busy",  32'(busy_s[1]),  32'd0);
    step();
    chk("flush_cap_valid", 32'(valid_s[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
